// File: rtl/freq_div_pkg.sv
// Shared constants and elaboration-time helpers for the programmable frequency divider.
package freq_div_pkg;

    localparam int DEF_DIV_DEFAULT = 50000;
    localparam int MIN_DIV         = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Channel-select width; a single channel still gets a one-bit select port.
    function automatic int ch_idx_w(input int n);
        return (clog2(n) > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/freq_div_channel.sv
// One divider channel: active/pending divisor, period counter, registered tick and square wave.
module freq_div_channel #(
    parameter int DIV_W   = 22,
    parameter int DEF_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             wr_en_i,
    input  logic [DIV_W-1:0] wr_div_i,
    output logic             tick_o,
    output logic             sq_o
);
    localparam logic [DIV_W-1:0] DEF = DIV_W'(DEF_DIV);

    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             wrap;

    always_comb begin
        pend_d = wr_en_i ? wr_div_i : pend_q;
        act_d  = act_q;
        cnt_d  = '0;
        tick_d = 1'b0;
        sq_d   = 1'b0;
        wrap   = (cnt_q == act_q - DIV_W'(1));
        if (!en_i) begin
            act_d = pend_d;
        end else begin
            tick_d = wrap;
            sq_d   = (cnt_q < (act_q >> 1));
            // pend_d already carries a same-cycle write, so a write landing on the wrap shapes the next period
            if (wrap) act_d = pend_d;
            else      cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q  <= DEF;
            pend_q <= DEF;
            cnt_q  <= '0;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            act_q  <= act_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;

endmodule

// File: rtl/prog_freq_divider.sv
// Multi-channel programmable frequency divider: write decode, error flag, scan counter,
// and N_CH independent divider channels.
module prog_freq_divider
    import freq_div_pkg::*;
#(
    parameter int  N_CH    = 4,
    parameter int  DIV_W   = 22,
    parameter int  SCN_W   = 2,
    parameter int  DEF_DIV = DEF_DIV_DEFAULT,
    localparam int CH_W    = ch_idx_w(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  en,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_err,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  sq,
    output logic [SCN_W-1:0] scan
);
    logic             ch_ok, div_ok, accept;
    logic             err_q, err_d;
    logic [SCN_W-1:0] scan_q, scan_d;

    // Widened compare so a non-power-of-two channel count rejects the unused select codes
    assign ch_ok  = (32'(cfg_ch) < 32'(N_CH));
    assign div_ok = (cfg_div >= DIV_W'(MIN_DIV));
    assign accept = cfg_we && ch_ok && div_ok;

    always_comb begin
        err_d  = cfg_we && !(ch_ok && div_ok);
        scan_d = scan_q + SCN_W'(tick[0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q  <= 1'b0;
            scan_q <= '0;
        end else begin
            err_q  <= err_d;
            scan_q <= scan_d;
        end
    end

    assign cfg_err = err_q;
    assign scan    = scan_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic wr_g;
        assign wr_g = accept && (32'(cfg_ch) == 32'(g));

        freq_div_channel #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en_i     (en[g]),
            .wr_en_i  (wr_g),
            .wr_div_i (cfg_div),
            .tick_o   (tick[g]),
            .sq_o     (sq[g])
        );
    end

endmodule

// File: tb/tb_prog_freq_divider.sv
// Self-checking bench for prog_freq_divider against a timestamp-based period model.
module tb_prog_freq_divider;

    localparam int NCH = 4;
    localparam int DEF = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [21:0] cfg_div;
    logic        cfg_err;
    logic [3:0]  tick, sq;
    logic [1:0]  scan;

    logic [2:0]  en3;
    logic        we3;
    logic [1:0]  ch3;
    logic [21:0] div3;
    logic        err3;
    logic [2:0]  tick3, sq3;
    logic [1:0]  scan3;

    int errors = 0;
    int checks = 0;

    prog_freq_divider #(.N_CH(4), .DIV_W(22), .SCN_W(2), .DEF_DIV(DEF)) u_dut (
        .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_err(cfg_err), .tick(tick), .sq(sq), .scan(scan)
    );

    prog_freq_divider #(.N_CH(3), .DIV_W(22), .SCN_W(2), .DEF_DIV(DEF)) u_dut3 (
        .clk(clk), .rst(rst), .en(en3), .cfg_we(we3), .cfg_ch(ch3), .cfg_div(div3),
        .cfg_err(err3), .tick(tick3), .sq(sq3), .scan(scan3)
    );

    always #5 clk = ~clk;

    // Model: each running channel has a period start edge, a length, and a pending length.
    int          cyc = 0;
    int          m_start[NCH];
    int          m_per[NCH];
    int          m_pend[NCH];
    logic [3:0]  exp_tick, exp_sq;
    logic [1:0]  exp_scan;
    logic        exp_err;

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_pend[i]  = DEF;
            m_per[i]   = DEF;
            m_start[i] = cyc + 1;
        end
        exp_tick = '0;
        exp_sq   = '0;
        exp_scan = '0;
        exp_err  = 1'b0;
    endfunction

    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            exp_scan = exp_scan + 2'(exp_tick[0]);
            exp_err  = cfg_we && ((cfg_div < 2) || (int'(cfg_ch) >= NCH));
            if (cfg_we && !exp_err) m_pend[cfg_ch] = int'(cfg_div);
            for (int i = 0; i < NCH; i++) begin
                if (en[i]) begin
                    int k;
                    k = cyc - m_start[i];
                    exp_sq[i]   = (k < m_per[i] / 2);
                    exp_tick[i] = (k == m_per[i] - 1);
                    if (exp_tick[i]) begin
                        m_start[i] = cyc + 1;
                        m_per[i]   = m_pend[i];
                    end
                end else begin
                    exp_sq[i]   = 1'b0;
                    exp_tick[i] = 1'b0;
                    m_start[i]  = cyc + 1;
                    m_per[i]    = m_pend[i];
                end
            end
        end
        #1;
    endtask

    // Wait for tick on a main-DUT channel; steps keep the model in lock-step.
    task automatic wait_tick(input int ch, input string name);
        int n;
        n = 0;
        while (tick[ch] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (tick[ch] !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout tick[%0d]=%b want 1 within 40 cycles", name, ch, tick[ch]);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({tick, sq, scan, cfg_err} !== 11'b0) begin
            errors++;
            $display("FAIL reset_async got tick=%b sq=%b scan=%0d err=%b want all 0", tick, sq, scan, cfg_err);
        end
        repeat (2) begin
            step();
            checks++;
            if ({tick, sq, scan, cfg_err} !== {exp_tick, exp_sq, exp_scan, exp_err}) begin
                errors++;
                $display("FAIL reset_hold got tick=%b sq=%b scan=%0d err=%b want tick=%b sq=%b scan=%0d err=%b",
                         tick, sq, scan, cfg_err, exp_tick, exp_sq, exp_scan, exp_err);
            end
        end
        rst = 1'b0;
        en  = 4'hF;
    endtask

    task automatic test_basic();
        repeat (24) begin
            step();
            checks++;
            if ({tick, sq, scan, cfg_err} !== {exp_tick, exp_sq, exp_scan, exp_err}) begin
                errors++;
                $display("FAIL basic cyc=%0d got tick=%b sq=%b scan=%0d err=%b want tick=%b sq=%b scan=%0d err=%b",
                         cyc, tick, sq, scan, cfg_err, exp_tick, exp_sq, exp_scan, exp_err);
            end
        end
    endtask

    task automatic test_write_mid();
        wait_tick(1, "write_mid");
        step();
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 22'd10;
        step();
        cfg_we = 1'b0;
        repeat (36) begin
            step();
            checks++;
            if ({tick, sq, scan, cfg_err} !== {exp_tick, exp_sq, exp_scan, exp_err}) begin
                errors++;
                $display("FAIL write_mid cyc=%0d got tick=%b sq=%b scan=%0d err=%b want tick=%b sq=%b scan=%0d err=%b",
                         cyc, tick, sq, scan, cfg_err, exp_tick, exp_sq, exp_scan, exp_err);
            end
        end
    endtask

    task automatic test_write_wrap();
        int gaps[2] = '{3, 6};
        int divs[2] = '{7, 3};
        for (int w = 0; w < 2; w++) begin
            wait_tick(2, "write_wrap");
            repeat (gaps[w]) step();
            cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 22'(divs[w]);
            step();
            cfg_we = 1'b0;
            repeat (24) begin
                step();
                checks++;
                if ({tick, sq, scan, cfg_err} !== {exp_tick, exp_sq, exp_scan, exp_err}) begin
                    errors++;
                    $display("FAIL write_wrap div=%0d cyc=%0d got tick=%b sq=%b scan=%0d err=%b want tick=%b sq=%b scan=%0d err=%b",
                             divs[w], cyc, tick, sq, scan, cfg_err, exp_tick, exp_sq, exp_scan, exp_err);
                end
            end
        end
    endtask

    task automatic test_reject();
        int bad[2] = '{1, 0};
        for (int w = 0; w < 2; w++) begin
            cfg_we = 1'b1; cfg_ch = 2'(w * 3); cfg_div = 22'(bad[w]);
            step();
            cfg_we = 1'b0;
            repeat (10) begin
                step();
                checks++;
                if ({tick, sq, scan, cfg_err} !== {exp_tick, exp_sq, exp_scan, exp_err}) begin
                    errors++;
                    $display("FAIL reject div=%0d cyc=%0d got tick=%b sq=%b scan=%0d err=%b want tick=%b sq=%b scan=%0d err=%b",
                             bad[w], cyc, tick, sq, scan, cfg_err, exp_tick, exp_sq, exp_scan, exp_err);
                end
            end
        end
    endtask

    task automatic test_disable();
        en[0] = 1'b0;
        step();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 22'd6;
        step();
        cfg_we = 1'b0;
        repeat (38) begin
            if (cyc % 40 == 18) en[0] = 1'b1;
            step();
            checks++;
            if ({tick, sq, scan, cfg_err} !== {exp_tick, exp_sq, exp_scan, exp_err}) begin
                errors++;
                $display("FAIL disable en0=%b cyc=%0d got tick=%b sq=%b scan=%0d err=%b want tick=%b sq=%b scan=%0d err=%b",
                         en[0], cyc, tick, sq, scan, cfg_err, exp_tick, exp_sq, exp_scan, exp_err);
            end
        end
        en[0] = 1'b1;
    endtask

    task automatic test_async_reset();
        wait_tick(1, "async_reset");
        step();
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 22'd9;
        step();
        cfg_we = 1'b0;
        step();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({tick, sq, scan, cfg_err} !== 11'b0) begin
            errors++;
            $display("FAIL async_reset_now got tick=%b sq=%b scan=%0d err=%b want all 0", tick, sq, scan, cfg_err);
        end
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 22'd9;
        repeat (2) step();
        cfg_we = 1'b0;
        rst    = 1'b0;
        repeat (20) begin
            step();
            checks++;
            if ({tick, sq, scan, cfg_err} !== {exp_tick, exp_sq, exp_scan, exp_err}) begin
                errors++;
                $display("FAIL async_reset cyc=%0d got tick=%b sq=%b scan=%0d err=%b want tick=%b sq=%b scan=%0d err=%b",
                         cyc, tick, sq, scan, cfg_err, exp_tick, exp_sq, exp_scan, exp_err);
            end
        end
    endtask

    task automatic test_random();
        repeat (400) begin
            cfg_we = 1'b0;
            if ($urandom_range(0, 19) == 0) en[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 5) == 0) begin
                cfg_we  = 1'b1;
                cfg_ch  = 2'($urandom_range(0, 3));
                cfg_div = 22'($urandom_range(0, 9));
            end
            step();
            checks++;
            if ({tick, sq, scan, cfg_err} !== {exp_tick, exp_sq, exp_scan, exp_err}) begin
                errors++;
                $display("FAIL random cyc=%0d got tick=%b sq=%b scan=%0d err=%b want tick=%b sq=%b scan=%0d err=%b",
                         cyc, tick, sq, scan, cfg_err, exp_tick, exp_sq, exp_scan, exp_err);
            end
        end
        cfg_we = 1'b0;
    endtask

    // Runs last: it clocks without stepping the main model.
    task automatic test_range();
        int n;
        n = 0;
        while (tick3[2] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        we3 = 1'b1; ch3 = 2'd3; div3 = 22'd5;
        @(posedge clk); #1;
        we3 = 1'b0;
        checks++;
        if (err3 !== 1'b1) begin
            errors++;
            $display("FAIL range_err got %b want 1", err3);
        end
        @(posedge clk); #1;
        checks++;
        if (err3 !== 1'b0) begin
            errors++;
            $display("FAIL range_err_clear got %b want 0", err3);
        end
        n = 0;
        while (tick3[2] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        n = 0;
        do begin @(posedge clk); #1; n++; end while (tick3[2] !== 1'b1 && n < 20);
        checks++;
        if (n != DEF) begin
            errors++;
            $display("FAIL range_period got %0d cycles want %0d", n, DEF);
        end
    endtask

    initial begin
        rst = 1'b1; en = 4'h0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = 22'd0;
        en3 = 3'b111; we3 = 1'b0; ch3 = 2'd0; div3 = 22'd0;
        model_reset();
        test_reset();
        test_basic();
        test_write_mid();
        test_write_wrap();
        test_reject();
        test_disable();
        test_async_reset();
        test_random();
        test_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
